// File: rtl/insn_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: architectural widths,
// the NOP encoding presented when no instruction is live, the FIFO entry
// layout and the fetch FSM state encoding.
package insn_fetch_pkg;

    localparam int INSN_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [INSN_W-1:0] NOP_INSN = 32'h6000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] insn;
    } fetch_entry_t;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, insn} FIFO between the instruction memory and the converter.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   push, wdata  write wdata at the tail
//   pop          drop the head
//   flush        empty the FIFO; wins over push and pop
//   count        current occupancy (0..2)
//   head         oldest entry; only meaningful when count != 0
module fetch_fifo
    import insn_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t wdata,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch stage. Issues word reads into a 1-cycle-latency
// instruction memory, buffers returned words with their PCs in a 2-entry
// FIFO and presents the FIFO head to the converter.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   redirect_valid   branch redirect; flushes everything, refetches at redirect_pc
//   redirect_pc      redirect target (low two bits ignored)
//   conv_stall       converter stall; holds the presented instruction
//   imem_en          memory read request this cycle
//   imem_addr        word address = req_pc[IMEM_AW+1:2]
//   imem_rdata       read data, valid the cycle after imem_en
//   insn_valid       pc_out/insn_out carry a live instruction
//   pc_out           PC of presented instruction (last presented PC when idle)
//   insn_out         presented instruction, NOP_INSN when idle
module insn_fetch
    import insn_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                IMEM_AW  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               conv_stall,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSN_W-1:0]  imem_rdata,
    output logic               insn_valid,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSN_W-1:0]  insn_out
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] last_pc_q;

    logic [1:0]        fifo_count;
    fetch_entry_t      fifo_head;
    fetch_entry_t      push_data;
    logic              push, pop, issue;
    logic [2:0]        occ;

    assign insn_valid = (fifo_count != 2'd0);
    assign pop        = insn_valid && !conv_stall && !redirect_valid;
    // A response arriving this cycle is dropped if a redirect is flushing.
    assign push       = inflight_q && !redirect_valid;
    assign push_data  = '{pc: infl_pc_q, insn: imem_rdata};

    // Slots already claimed after this cycle's pop; keeps count+inflight <= 2
    // so an in-flight response always has room.
    assign occ = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        infl_pc_d  = infl_pc_q;
        inflight_d = 1'b0;     // a request lives exactly one cycle
        issue      = 1'b0;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (!redirect_valid && occ < 3'd2) begin
                    issue      = 1'b1;
                    inflight_d = 1'b1;
                    infl_pc_d  = req_pc_q;
                    req_pc_d   = req_pc_q + 32'd4;
                end
            end
        endcase
        if (redirect_valid) begin
            req_pc_d = redirect_pc & 32'hFFFF_FFFC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            req_pc_q   <= RESET_PC;
            infl_pc_q  <= '0;
            inflight_q <= 1'b0;
            last_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            infl_pc_q  <= infl_pc_d;
            inflight_q <= inflight_d;
            if (insn_valid) begin
                last_pc_q <= fifo_head.pc;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .flush (redirect_valid),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign imem_en   = issue;
    assign imem_addr = req_pc_q[IMEM_AW+1:2];
    assign pc_out    = insn_valid ? fifo_head.pc   : last_pc_q;
    assign insn_out  = insn_valid ? fifo_head.insn : NOP_INSN;

endmodule

// File: tb/tb_insn_fetch.sv
module tb_insn_fetch;
    import insn_fetch_pkg::*;

    localparam int          AW  = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          conv_stall;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata = 32'h0;
    logic          insn_valid;
    logic [31:0]   pc_out;
    logic [31:0]   insn_out;

    insn_fetch #(.RESET_PC(RPC), .IMEM_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .conv_stall(conv_stall),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .insn_valid(insn_valid), .pc_out(pc_out), .insn_out(insn_out)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [16];
    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the converter sees the program-order PC stream, restarted
    // at each redirect target; an instruction is live from the 3rd cycle after
    // boot/redirect onward.
    int          q;        // cycles since boot or last redirect
    logic [31:0] exp_pc;   // PC that should be at the head
    logic [31:0] last_pc;  // last PC actually presented

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mword(input logic [31:0] pc);
        return 32'h1000_0000 + ((pc >> 2) & 32'hF);
    endfunction

    task automatic model_reset();
        q       = 0;
        exp_pc  = RPC;
        last_pc = RPC;
    endtask

    // Called at a negedge: drive this cycle's inputs, check, advance the model.
    task automatic cyc(input logic s, input logic r, input logic [31:0] rp);
        logic ev;
        conv_stall     = s;
        redirect_valid = r;
        redirect_pc    = rp;
        #1;
        ev = (q >= 3);
        chk("insn_valid", 32'(insn_valid), 32'(ev));
        if (ev) begin
            chk("pc_out", pc_out, exp_pc);
            chk("insn_out", insn_out, mword(exp_pc));
        end else begin
            chk("pc_out_idle", pc_out, last_pc);
            chk("insn_out_nop", insn_out, NOP_INSN);
        end
        if (q == 0 || r) chk("imem_en_quiet", 32'(imem_en), 32'd0);
        else if (q == 1) begin
            chk("imem_en_first", 32'(imem_en), 32'd1);
            chk("imem_addr_first", 32'(imem_addr), (exp_pc >> 2) & 32'hF);
        end
        if (ev) last_pc = exp_pc;
        if (r) begin
            exp_pc = rp & 32'hFFFF_FFFC;
            q      = 1;
        end else begin
            if (ev && !s) exp_pc = exp_pc + 32'd4;
            if (q < 1000) q++;
        end
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] rp);
        cyc(s, r, rp);
        @(negedge clk);
    endtask

    typedef struct {
        logic        stall;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        en;
    } vec_t;
    vec_t tbl [13];

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = 32'h1000_0000 + 32'(k);
        // Cycles 0..12 after reset: boot, fill, stall 5 cycles at pc 8, resume.
        tbl[0]  = '{1'b0, 1'b0, 32'd0,  NOP_INSN,       1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'd0,  NOP_INSN,       1'b1};
        tbl[2]  = '{1'b0, 1'b0, 32'd0,  NOP_INSN,       1'b1};
        tbl[3]  = '{1'b0, 1'b1, 32'd0,  32'h1000_0000,  1'b1};
        tbl[4]  = '{1'b0, 1'b1, 32'd4,  32'h1000_0001,  1'b1};
        for (int k = 5; k < 10; k++) tbl[k] = '{1'b1, 1'b1, 32'd8, 32'h1000_0002, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'd8,  32'h1000_0002,  1'b1};
        tbl[11] = '{1'b0, 1'b1, 32'd12, 32'h1000_0003,  1'b1};
        tbl[12] = '{1'b0, 1'b1, 32'd16, 32'h1000_0004,  1'b1};

        rst_n = 1'b0; conv_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        #1;
        chk("rst_valid", 32'(insn_valid), 32'd0);
        chk("rst_insn", insn_out, NOP_INSN);
        chk("rst_pc", pc_out, RPC);
        chk("rst_en", 32'(imem_en), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].stall, 1'b0, 32'h0);
            chk("tbl_valid", 32'(insn_valid), 32'(tbl[i].valid));
            chk("tbl_pc", pc_out, tbl[i].pc);
            chk("tbl_insn", insn_out, tbl[i].insn);
            chk("tbl_en", 32'(imem_en), 32'(tbl[i].en));
            @(negedge clk);
        end

        // Redirect to 0x22 while streaming (pc 20 presented).
        step(1'b0, 1'b1, 32'h22);
        cyc(1'b0, 1'b0, 32'h0);
        chk("redir_en", 32'(imem_en), 32'd1);
        chk("redir_addr", 32'(imem_addr), 32'd8);
        chk("redir_v1", 32'(insn_valid), 32'd0);
        @(negedge clk);
        cyc(1'b0, 1'b0, 32'h0);
        chk("redir_v2", 32'(insn_valid), 32'd0);
        @(negedge clk);
        cyc(1'b0, 1'b0, 32'h0);
        chk("redir_pc", pc_out, 32'h20);
        chk("redir_insn", insn_out, 32'h1000_0008);
        @(negedge clk);

        // Fill the FIFO under stall, then redirect with the stall held.
        repeat (3) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h100);
        cyc(1'b1, 1'b0, 32'h0);
        chk("stall_redir_flush", 32'(insn_valid), 32'd0);
        @(negedge clk);
        repeat (5) step(1'b0, 1'b0, 32'h0);

        // Word-address wrap: fetch 56, 60, 64 -> addresses 14, 15, 0.
        step(1'b0, 1'b1, 32'd56);
        cyc(1'b0, 1'b0, 32'h0);
        chk("wrap_a14", 32'(imem_addr), 32'd14);
        @(negedge clk);
        cyc(1'b0, 1'b0, 32'h0);
        chk("wrap_a15", 32'(imem_addr), 32'd15);
        @(negedge clk);
        cyc(1'b0, 1'b0, 32'h0);
        chk("wrap_a0", 32'(imem_addr), 32'd0);
        @(negedge clk);
        step(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("wrap_pc64", pc_out, 32'd64);
        chk("wrap_insn", insn_out, 32'h1000_0000);
        @(negedge clk);

        // Randomized traffic, including redirects near the top of the 32-bit space.
        for (int i = 0; i < 3000; i++) begin
            logic        s, r;
            logic [31:0] rp;
            s  = ($urandom % 10) < 3;
            r  = (q >= 1) && (($urandom % 20) == 0);
            rp = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : ($urandom % 128);
            step(s, r, rp);
        end

        // Reset mid-stream with a request in flight.
        repeat (6) step(1'b0, 1'b0, 32'h0);
        chk("pre_rst_inflight", 32'(dut.inflight_q), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(insn_valid), 32'd0);
        chk("mid_rst_insn", insn_out, NOP_INSN);
        chk("mid_rst_pc", pc_out, RPC);
        chk("mid_rst_en", 32'(imem_en), 32'd0);
        chk("mid_rst_addr", 32'(imem_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (10) step(1'b0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
